// File: rtl/div8_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div8_pkg;

    localparam int DIV_W = 8;
    localparam int CNT_W = 3;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_W-1:0] Q_DBZ = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div8_seq_sub9.sv
// Combinational (N)-bit subtractor a + ~b + 1; borrow is the inverted carry out.
module sub9 #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic carry;

    assign {carry, diff} = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    assign borrow        = ~carry;

endmodule

// File: rtl/div8_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
module div8_seq
    import div8_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output state_t       dbg_state_o
);

    // Handshake: start is sampled on a rising edge only while busy is low (IDLE or
    // DONE); a start seen while busy is dropped. done pulses for exactly one cycle
    // and the result registers hold from that cycle until the next accepted start.

    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [W-1:0]     dq_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     dvs_q;
    logic [W-1:0]     quot_q;
    logic [W-1:0]     rout_q;
    logic             dbz_q;
    logic             busy_q;
    logic             done_q;

    logic [W:0]       trial;
    logic [W:0]       diff;
    logic             borrow;
    logic [W-1:0]     rem_d;
    logic [W-1:0]     dq_d;

    assign trial = {rem_q, dq_q[W-1]};

    sub9 #(.N(W + 1)) u_sub (
        .a      (trial),
        .b      ({1'b0, dvs_q}),
        .diff   (diff),
        .borrow (borrow)
    );

    // Restore on borrow; the shifted-in quotient bit is the "no borrow" flag.
    always_comb begin
        rem_d = borrow ? trial[W-1:0] : diff[W-1:0];
        dq_d  = {dq_q[W-2:0], ~borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rout_q  <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start && (divisor != '0)) begin
                        state_q <= CALC;
                        dq_q    <= dividend;
                        rem_q   <= '0;
                        dvs_q   <= divisor;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end else if (start) begin
                        state_q <= DONE;
                        quot_q  <= Q_DBZ;
                        rout_q  <= dividend;
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    dq_q    <= dq_d;
                    rem_q   <= rem_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CNT_LAST) begin
                        state_q <= DONE;
                        quot_q  <= dq_d;
                        rout_q  <= rem_d;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rout_q;
    assign div_by_zero = dbz_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: directed scenarios plus randomized operands vs an arithmetic model.
module tb_div8_seq;
    import div8_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    state_t     dbg_state;

    int checks = 0;
    int errors = 0;

    div8_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drivers: every task is entered and left at a falling edge.
    task automatic start_pulse(input logic [7:0] a, input logic [7:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Returns the number of rising edges after the accepting edge until done is seen.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            edges++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("no_busy_with_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done) n++;
            @(negedge clk);
        end
    endtask

    // Reference model: plain arithmetic from the operand values.
    task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] eq;
        logic [7:0] er;
        logic       ez;
        if (b == 8'd0) begin
            eq = 8'hFF;
            er = a;
            ez = 1'b1;
        end else begin
            eq = 8'(int'(a) / int'(b));
            er = 8'(int'(a) % int'(b));
            ez = 1'b0;
        end
        chk({tag, "_quotient"}, {24'd0, quotient}, {24'd0, eq});
        chk({tag, "_remainder"}, {24'd0, remainder}, {24'd0, er});
        chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        if (b != 8'd0) begin
            chk({tag, "_identity"}, int'(quotient) * int'(b) + int'(remainder), {24'd0, a});
            chk({tag, "_rem_lt_div"}, {31'd0, remainder < b}, 32'd1);
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b);
        int edges;
        int bc;
        start_pulse(a, b);
        wait_done(edges, bc);
        chk({tag, "_latency"}, edges, (b == 8'd0) ? 0 : 8);
        chk({tag, "_busy_cycles"}, bc, (b == 8'd0) ? 0 : 8);
        check_result(tag, a, b);
    endtask

    logic [7:0] corner_a[8] = '{8'd0, 8'd255, 8'd254, 8'd0, 8'd1, 8'd128, 8'd255, 8'd7};
    logic [7:0] corner_b[8] = '{8'd1, 8'd255, 8'd255, 8'd0, 8'd0, 8'd3, 8'd128, 8'd7};

    initial begin
        int edges;
        int bc;
        int nd;
        logic [7:0] ra;
        logic [7:0] rb;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quotient", {24'd0, quotient}, 32'd0);
        chk("rst_remainder", {24'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_done", {31'd0, done}, 32'd0);

        // 100 / 7
        run_op("basic", 8'd100, 8'd7);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("basic_hold_q", {24'd0, quotient}, 32'd14);

        // Back-to-back: second start driven during the done cycle of the first.
        run_op("b2b_first", 8'd255, 8'd1);
        start_pulse(8'd5, 8'd9);
        chk("b2b_accepted_busy", {31'd0, busy}, 32'd1);
        chk("b2b_accepted_done", {31'd0, done}, 32'd0);
        chk("b2b_hold_q", {24'd0, quotient}, 32'd255);
        wait_done(edges, bc);
        chk("b2b_latency", edges, 8);
        check_result("b2b_second", 8'd5, 8'd9);
        @(negedge clk);

        // Divide by zero, then an ordinary op clears the flag.
        run_op("dbz", 8'd200, 8'd0);
        @(negedge clk);
        chk("dbz_hold", {31'd0, div_by_zero}, 32'd1);
        run_op("after_dbz", 8'd9, 8'd3);
        @(negedge clk);

        // Start while busy is ignored.
        start_pulse(8'd100, 8'd7);
        repeat (2) @(negedge clk);
        start_pulse(8'd50, 8'd5);
        count_dones(20, nd);
        chk("ignore_done_count", nd, 1);
        check_result("ignore", 8'd100, 8'd7);

        // Reset mid-calculation aborts.
        start_pulse(8'd255, 8'd2);
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_quotient", {24'd0, quotient}, 32'd0);
        chk("abort_remainder", {24'd0, remainder}, 32'd0);
        chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(12, nd);
        chk("abort_no_done", nd, 0);
        chk("abort_state", {30'd0, dbg_state}, {30'd0, IDLE});

        for (int i = 0; i < 8; i++) begin
            run_op("corner", corner_a[i], corner_b[i]);
            @(negedge clk);
        end

        // Random operands, back-to-back on odd iterations.
        for (int i = 0; i < 3000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_op("rand", ra, rb);
            if (i % 2 == 0) begin
                @(negedge clk);
                chk("rand_done_drop", {31'd0, done}, 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
